// File: rtl/fp_add_sub_pkg.sv
// fp_add_sub_pkg: shared types and helpers for the pipelined FP adder.
// Operand classes, flag bit positions, canonical quiet-NaN builder.
package fp_add_sub_pkg;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    NAN
  } fp_class_e;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // sign 0, exponent all ones, fraction MSB set
  function automatic logic [63:0] qnan(
    input int exp_w,
    input int man_w
  );
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++)
      v[man_w+i] = 1'b1;
    v[man_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: parametrised leading-zero counter.
// Returns N when the input is all zeros.
module fp_lzc #(
  parameter int N  = 27,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  din,
  output logic [CW-1:0] cnt
);

  // highest set bit wins: later iterations overwrite
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++)
      if (din[i]) cnt = CW'(N - 1 - i);
  end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: 3-stage IEEE-754 add/sub, RNE, valid/ready, whole-pipe stall.
// Macro FP_ADD_SUB_PIPE_DENORM_EN enables gradual underflow; else subnormals flush.
module fp_add_sub_pipe
  import fp_add_sub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   operation_select,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int X  = MAN_W + 4;
  localparam int S  = MAN_W + 5;
  localparam int CW = $clog2(X + 1);
  localparam int AW = ((EXP_W > CW) ? EXP_W : CW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, MAN_W));

  typedef struct packed {
    fp_class_e        c;
    logic [EXP_W-1:0] e;
    logic [M-1:0]     m;
  } unp_t;

  typedef struct packed {
    logic             sx;
    logic             sy;
    logic [EXP_W-1:0] ex;
    logic [EXP_W-1:0] d;
    logic [M-1:0]     mx;
    logic [M-1:0]     my;
    logic             spec;
    logic             inv;
    logic [W-1:0]     res;
  } s1_t;

  typedef struct packed {
    logic             sx;
    logic             zs;
    logic [EXP_W-1:0] ex;
    logic [S-1:0]     sum;
    logic             spec;
    logic             inv;
    logic [W-1:0]     res;
  } s2_t;

  function automatic unp_t unpack(input logic [W-1:0] v);
    unp_t u;
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] f;
    ef  = v[W-2:MAN_W];
    f   = v[MAN_W-1:0];
    u.c = NORM;
    u.e = ef;
    u.m = {1'b1, f};
    if (ef == '0) begin
      u.m = {1'b0, f};
      if (f == '0) begin
        u.c = ZERO;
      end else begin
`ifdef FP_ADD_SUB_PIPE_DENORM_EN
        u.c = SUB;
        u.e = EXP_W'(1);
`else
        u.c = ZERO;
        u.m = '0;
`endif
      end
    end else if (ef == EMAX) begin
      u.c = (f == '0) ? INF : NAN;
    end
    return u;
  endfunction

  logic en, rdy_q, v1, v2, v3;

  assign en        = ~v3 | out_ready;
  assign in_ready  = en & rdy_q;
  assign out_valid = v3;

  // stage valid bits; bubbles advance as valid=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (en) begin
        v1 <= in_valid & in_ready;
        v2 <= v1;
        v3 <= v2;
      end
    end
  end

  unp_t ua, ub;
  logic sa, sb, nan_a, nan_b;
  s1_t  s1_d, s1_q;

  // unpack, classify, order by magnitude, resolve specials early
  always_comb begin
    ua    = unpack(a);
    ub    = unpack(b);
    sa    = a[W-1];
    sb    = b[W-1] ^ ~operation_select;
    nan_a = ua.c == NAN;
    nan_b = ub.c == NAN;
    s1_d  = '0;
    if ({ua.e, ua.m} >= {ub.e, ub.m}) begin
      s1_d.sx = sa;
      s1_d.sy = sb;
      s1_d.ex = ua.e;
      s1_d.mx = ua.m;
      s1_d.my = ub.m;
      s1_d.d  = ua.e - ub.e;
    end else begin
      s1_d.sx = sb;
      s1_d.sy = sa;
      s1_d.ex = ub.e;
      s1_d.mx = ub.m;
      s1_d.my = ua.m;
      s1_d.d  = ub.e - ua.e;
    end
    if (nan_a | nan_b) begin
      s1_d.spec = 1'b1;
      s1_d.res  = QNAN;
      s1_d.inv  = (nan_a & ~a[MAN_W-1]) |
                  (nan_b & ~b[MAN_W-1]);
    end else if (ua.c == INF && ub.c == INF && sa != sb) begin
      s1_d.spec = 1'b1;
      s1_d.res  = QNAN;
      s1_d.inv  = 1'b1;
    end else if (ua.c == INF) begin
      s1_d.spec = 1'b1;
      s1_d.res  = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (ub.c == INF) begin
      s1_d.spec = 1'b1;
      s1_d.res  = {sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  // stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  s1_q <= '0;
    else if (en) s1_q <= s1_d;
  end

  logic [2*X-1:0] wide;
  logic [X-1:0]   xal, yal;
  int             sh;
  s2_t            s2_d, s2_q;

  // align smaller operand with sticky jam, then add or subtract
  always_comb begin
    sh   = (int'(s1_q.d) > X - 1) ? X - 1 : int'(s1_q.d);
    wide = {s1_q.my, 3'b000, {X{1'b0}}} >> sh;
    xal  = {s1_q.mx, 3'b000};
    yal  = wide[2*X-1:X];
    yal[0] = yal[0] | (|wide[X-1:0]);
    s2_d.sx   = s1_q.sx;
    s2_d.zs   = s1_q.sx & s1_q.sy;
    s2_d.ex   = s1_q.ex;
    s2_d.spec = s1_q.spec;
    s2_d.inv  = s1_q.inv;
    s2_d.res  = s1_q.res;
    if (s1_q.sx ^ s1_q.sy)
      s2_d.sum = {1'b0, xal} - {1'b0, yal};
    else
      s2_d.sum = {1'b0, xal} + {1'b0, yal};
  end

  // stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  s2_q <= '0;
    else if (en) s2_q <= s2_d;
  end

  logic [CW-1:0] lz;
  logic [AW-1:0] ex_w, lz_w, en_e, ef;
  logic [X-1:0]  nm;
  logic [M:0]    mr;
  logic          tiny, rnd, inx;
  logic [W-1:0]  res_d;
  logic [3:0]    flg_d;

  fp_lzc #(
    .N  (X),
    .CW (CW)
  ) u_lzc (
    .din (s2_q.sum[X-1:0]),
    .cnt (lz)
  );

  // normalise, round to nearest even, pack and pick special results
  always_comb begin
    ex_w = AW'(s2_q.ex);
    lz_w = AW'(lz);
    tiny = 1'b0;
    if (s2_q.sum[S-1]) begin
      nm   = {s2_q.sum[S-1:2], |s2_q.sum[1:0]};
      en_e = ex_w + AW'(1);
    end else if (lz_w < ex_w) begin
      nm   = s2_q.sum[X-1:0] << lz;
      en_e = ex_w - lz_w;
    end else begin
      tiny = 1'b1;
      en_e = '0;
`ifdef FP_ADD_SUB_PIPE_DENORM_EN
      nm   = s2_q.sum[X-1:0] << (ex_w - AW'(1));
`else
      nm   = s2_q.sum[X-1:0];
`endif
    end
    rnd   = nm[2] & (nm[3] | nm[1] | nm[0]);
    inx   = |nm[2:0];
    mr    = {1'b0, nm[X-1:3]} + (M+1)'(rnd);
    ef    = tiny ? AW'(mr[MAN_W]) : en_e + AW'(mr[M]);
    res_d = {s2_q.sx, ef[EXP_W-1:0], mr[MAN_W-1:0]};
    flg_d = '0;
    flg_d[FLG_INEXACT] = inx;
    if (s2_q.spec) begin
      res_d = s2_q.res;
      flg_d = '0;
      flg_d[FLG_INVALID] = s2_q.inv;
    end else if (s2_q.sum == '0) begin
      res_d = {s2_q.zs, {(W-1){1'b0}}};
      flg_d = '0;
    end else if (ef >= AW'(EMAX)) begin
      res_d = {s2_q.sx, EMAX, {MAN_W{1'b0}}};
      flg_d[FLG_OVERFLOW] = 1'b1;
      flg_d[FLG_INEXACT]  = 1'b1;
    end else if (tiny) begin
`ifdef FP_ADD_SUB_PIPE_DENORM_EN
      flg_d[FLG_UNDERFLOW] = inx;
`else
      res_d = {s2_q.sx, {(W-1){1'b0}}};
      flg_d[FLG_UNDERFLOW] = 1'b1;
      flg_d[FLG_INEXACT]   = 1'b1;
`endif
    end
  end

  // output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (en) begin
      result <= res_d;
      flags  <= flg_d;
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb_fp_add_sub_pipe: directed vectors for the pipelined FP add/sub.
// Covers reset, specials, signs, rounding, overflow, stall and mid-stream reset.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        operation_select = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

`ifdef FP_ADD_SUB_PIPE_DENORM_EN
  localparam logic [31:0] DN_RES   = 32'h0000_0002;
  localparam logic [31:0] TINY_RES = 32'h0040_0000;
  localparam logic [3:0]  TINY_FLG = 4'b0000;
`else
  localparam logic [31:0] DN_RES   = 32'h0000_0000;
  localparam logic [31:0] TINY_RES = 32'h0000_0000;
  localparam logic [3:0]  TINY_FLG = 4'b0011;
`endif

  logic [31:0] sb_tab [8] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000
  };
  logic [31:0] ex_tab [8] = '{
    32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000
  };

  fp_add_sub_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a                (a),
    .b                (b),
    .operation_select (operation_select),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .flags            (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_op(
    input  string       tag,
    input  logic [31:0] va,
    input  logic [31:0] vb,
    input  logic        op,
    input  logic [31:0] er,
    input  logic [3:0]  ef,
    output int          lat
  );
    @(negedge clk);
    a = va;
    b = vb;
    operation_select = op;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    int lat;
    int ii;
    int oi;
    int cyc;
    int stale;
    logic acc;
    logic con;

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_flg", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    // basic add and latency
    run_op("add12", 32'h3F800000, 32'h40000000, 1'b1,
           32'h40400000, 4'b0000, lat);
    chk("latency", 32'(lat), 32'd3);

    // specials
    run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b0,
           32'h7FC00000, 4'b1000, lat);
    run_op("inf_p_neg", 32'h7F800000, 32'hC0000000, 1'b1,
           32'h7F800000, 4'b0000, lat);
    run_op("qnan_in", 32'h7FC00000, 32'h3F800000, 1'b1,
           32'h7FC00000, 4'b0000, lat);
    run_op("snan_in", 32'h7F800001, 32'h00000000, 1'b1,
           32'h7FC00000, 4'b1000, lat);

    // zero and sign handling
    run_op("one_m_one", 32'h3F800000, 32'h3F800000, 1'b0,
           32'h00000000, 4'b0000, lat);
    run_op("nz_p_nz", 32'h80000000, 32'h80000000, 1'b1,
           32'h80000000, 4'b0000, lat);
    run_op("nz_m_pz", 32'h80000000, 32'h00000000, 1'b0,
           32'h80000000, 4'b0000, lat);
    run_op("neg_add", 32'hBF800000, 32'hBF800000, 1'b1,
           32'hC0000000, 4'b0000, lat);
    run_op("three_m_one", 32'h40400000, 32'h3F800000, 1'b0,
           32'h40000000, 4'b0000, lat);

    // overflow and rounding
    run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1,
           32'h7F800000, 4'b0101, lat);
    run_op("tie_even", 32'h3F800000, 32'h33800000, 1'b1,
           32'h3F800000, 4'b0001, lat);

    // subnormal handling
    run_op("denorm", 32'h00000001, 32'h00000001, 1'b1,
           DN_RES, 4'b0000, lat);
    run_op("tiny", 32'h00C00000, 32'h00800000, 1'b0,
           TINY_RES, TINY_FLG, lat);

    // streaming with a 3-cycle consumer stall
    ii = 0;
    oi = 0;
    cyc = 0;
    while (oi < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = (ii < 8);
      a = 32'h3F800000;
      b = sb_tab[(ii < 8) ? ii : 7];
      operation_select = 1'b1;
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        chk("stall_rdy", 32'(in_ready), 32'd0);
        if (out_valid)
          chk("stall_hold", result, ex_tab[oi]);
      end
      acc = in_valid & in_ready;
      con = out_valid & out_ready;
      if (con) begin
        chk($sformatf("strm%0d", oi), result, ex_tab[oi]);
        oi++;
      end
      if (acc) ii++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("strm_out_cnt", 32'(oi), 32'd8);
    chk("strm_in_cnt", 32'(ii), 32'd8);
    repeat (4) @(negedge clk);
    chk("strm_drain", 32'(out_valid), 32'd0);

    // reset while ops are in flight
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h3F800000;
      b = sb_tab[k];
    end
    #1;
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_res", result, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    chk("rdy_rel", 32'(in_ready), 32'd1);
    run_op("post_rst", 32'h3F800000, 32'h40000000, 1'b1,
           32'h40400000, 4'b0000, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_add_sub_pipe.md
Name: fp_add_sub_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor. Successor to the combinational single-precision add/sub datapath.
- Configurable exponent and mantissa widths, round-to-nearest-even, full special-value handling and exception flags.
- Valid/ready handshake on both sides, with a whole-pipe stall.
- Sits between the operand issue logic and the result writeback; the existing add/sub assertion checker binds to its output side.

Parameters:
- EXP_W, 8, exponent field width (≥ 3).
- MAN_W, 23, stored fraction width (≥ 2).
- Derived: W = 1 + EXP_W + MAN_W; BIAS = 2^(EXP_W-1) - 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A
- b  in  W  operand B
- operation_select  in  1  1 = a+b, 0 = a-b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- result  out  W  packed result
- flags  out  4  {invalid, overflow, underflow, inexact}, qualified by out_valid

Behaviour:
- Reset:
  - Asynchronous, active-low; clears every stage valid bit.
  - out_valid=0, result=0, flags=0. in_ready=1 one cycle after release.
  - Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Handshake:
  - Pipeline enable en = ~out_valid | out_ready; in_ready = en.
  - Transfer occurs when in_valid & in_ready. Output is consumed when out_valid & out_ready.
  - When en=0, all stages hold; result and flags stay stable while out_valid & ~out_ready.
  - Bubbles propagate with valid=0. Throughput is 1 op/cycle; latency is 3 cycles from input transfer to out_valid (unstalled).
- Stage 1 (unpack):
  - Effective sign of b = b[W-1] ^ ~operation_select.
  - Classify each operand: zero / subnormal / normal / inf / NaN.
  - Swap so that |x| ≥ |y|; compute exponent difference d; effective op = add if signs are equal, else sub.
- Stage 2 (align/add):
  - Shift the smaller mantissa right by min(d, MAN_W+3) into guard/round/sticky.
  - Sticky is the OR of all bits shifted out.
  - (MAN_W+4)-bit add or subtract.
- Stage 3 (normalise/round/pack):
  - Leading-zero count, then shift left, or right by 1 on carry-out.
  - Round to nearest even. Re-normalise on rounding carry.
  - Exponent ≥ 2^EXP_W-1 → ±inf, overflow=1, inexact=1.
- Special cases (priority order):
  1. Any NaN input → canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 only for a signalling NaN input.
  2. inf and inf of opposite effective sign → qNaN, invalid=1.
  3. inf with anything else → that inf, sign preserved.
  4. Exact zero result → +0, except (-0)+(-0) and (-0)-(+0) → -0.
- Flags:
  - inexact = any of guard/round/sticky set after alignment or normalisation.
  - underflow = result is tiny (before rounding) and inexact.
- Result is a pure function of the operands; no state carries between operations.

Optional Feature:
- Macro FP_ADD_SUB_PIPE_DENORM_EN.
- Defined: subnormal inputs use hidden bit 0 and exponent 1. Subnormal results are produced with gradual underflow.
- Undefined: subnormal inputs are flushed to signed zero before stage 1. Subnormal results are flushed to signed zero with underflow=1 and inexact=1. The stage-3 denormal shifter is removed.

Decomposition:
- Package fp_add_sub_pkg holds:
  - typedef fp_class_e {ZERO, SUB, NORM, INF, NAN}
  - flag bit index constants FLG_INVALID=3, FLG_OVERFLOW=2, FLG_UNDERFLOW=1, FLG_INEXACT=0
  - function qnan(EXP_W, MAN_W)
- One sub-module, fp_lzc: parametrised leading-zero counter, instantiated in stage 3.

Test Plan (default parameters):
- Add: 3F800000 + 40000000, op=1 → 40400000, flags=0, out_valid exactly 3 cycles after the input transfer.
- Specials:
  - 7F800000 sub 7F800000 → 7FC00000, invalid=1.
  - 7F800000 + C0000000 → 7F800000, flags=0.
- Zero/sign:
  - 3F800000 sub 3F800000 → 00000000.
  - 80000000 + 80000000 → 80000000.
  - BF800000 + BF800000 → C0000000.
- Overflow and rounding:
  - 7F7FFFFF + 7F7FFFFF → 7F800000, overflow=1, inexact=1.
  - 3F800000 + 33800000 → 3F800000 (tie to even), inexact=1.
- Stall: stream 8 ops back-to-back with out_ready=0 for cycles 4–6 → in_ready=0 during the stall, no loss or duplication, order preserved. Assert rst_n=0 mid-stream → out_valid=0 immediately; no stale result after release.
- Denormals: 00000001 + 00000001 → 00000002 with FP_ADD_SUB_PIPE_DENORM_EN defined; 00000000 without it.
